// File: rtl/game_input_pkg.sv
// Shared definitions for the 2048 button-input path.
// Holds the direction encoding used on move_dir, the scheduler state enum,
// the default timing constants for a 25 MHz clock and the press priority
// encoder.
package game_input_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } sched_state_e;

   // 500 ms first repeat, 200 ms subsequent repeats at 25 MHz
   localparam int unsigned DEF_REPEAT_DELAY = 12_500_000;
   localparam int unsigned DEF_REPEAT_RATE  = 5_000_000;
   localparam int unsigned DEF_CNT_W        = 24;

   // Lowest button index wins: up > right > down > left
   function automatic logic [1:0] prio_dir(input logic [3:0] e);
      logic [1:0] d;
      d = DIR_UP;
      if (e[0])      d = DIR_UP;
      else if (e[1]) d = DIR_RIGHT;
      else if (e[2]) d = DIR_DOWN;
      else if (e[3]) d = DIR_LEFT;
      return d;
   endfunction

endpackage

// File: rtl/move_input_scheduler_repeat_timer.sv
// repeat_timer: loadable down-counter used for button auto-repeat.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - load load_val this cycle (wins over en)
//   load_val    - value loaded on load
//   en          - count down by one this cycle; saturates at zero
//   zero        - counter currently equals zero
module repeat_timer
   import game_input_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/move_input_scheduler.sv
// move_input_scheduler: turns the four debounced direction buttons into
// single move commands on a valid/ready handshake, with fixed-priority
// resolution of simultaneous presses and optional auto-repeat while held.
// Ports:
//   clk, rst_n  - 25 MHz clock, synchronous active-low reset
//   btn[3:0]    - debounced buttons: [0] up, [1] right, [2] down, [3] left
//   move_ready  - engine accepts the pending command this cycle
//   move_valid  - a command is pending
//   move_dir    - 0 up, 1 right, 2 down, 3 left (valid with move_valid)
//   move_repeat - pending command is an auto-repeat
//   overrun     - one-cycle pulse when a press edge was dropped
module move_input_scheduler
   import game_input_pkg::*;
#(
   parameter bit          REPEAT_EN    = 1'b1,
   parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic       move_repeat,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] LOAD_FIRST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] LOAD_REPEAT = CNT_W'(REPEAT_RATE - 1);

   sched_state_e     state_q, state_d;
   logic [3:0]       btn_q;
   logic             valid_q, valid_d;
   logic [1:0]       dir_q, dir_d;
   logic             repeat_q, repeat_d;
   logic             overrun_q, overrun_d;

   logic [3:0]       btn_edge;
   logic [1:0]       win_dir;
   logic             multi_edge;
   logic             held;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_en;
   logic             tmr_zero;

   assign btn_edge   = btn & ~btn_q;
   assign win_dir    = prio_dir(btn_edge);
   // More than one bit set: clearing the lowest set bit leaves something
   assign multi_edge = |(btn_edge & (btn_edge - 4'd1));
   assign held       = btn[dir_q];
   assign tmr_en     = (state_q == HOLD);

   repeat_timer #(
      .CNT_W(CNT_W)
   ) u_repeat_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dir_d        = dir_q;
      repeat_d     = repeat_q;
      overrun_d    = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;

      case (state_q)
         IDLE: begin
            if (|btn_edge) begin
               valid_d   = 1'b1;
               dir_d     = win_dir;
               repeat_d  = 1'b0;
               overrun_d = multi_edge;
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            // A command is already pending, so every new press is lost
            overrun_d = |btn_edge;
            if (valid_q && move_ready) begin
               valid_d = 1'b0;
               if (REPEAT_EN && held) begin
                  state_d      = HOLD;
                  tmr_load     = 1'b1;
                  tmr_load_val = repeat_q ? LOAD_REPEAT : LOAD_FIRST;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         HOLD: begin
            // A fresh press always beats the repeat of the held button
            if (|btn_edge) begin
               valid_d   = 1'b1;
               dir_d     = win_dir;
               repeat_d  = 1'b0;
               overrun_d = multi_edge;
               state_d   = ISSUE;
            end else if (!held) begin
               state_d = IDLE;
            end else if (tmr_zero) begin
               valid_d  = 1'b1;
               repeat_d = 1'b1;
               state_d  = ISSUE;
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         btn_q     <= '0;
         valid_q   <= 1'b0;
         dir_q     <= DIR_UP;
         repeat_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         btn_q     <= btn;
         valid_q   <= valid_d;
         dir_q     <= dir_d;
         repeat_q  <= repeat_d;
         overrun_q <= overrun_d;
      end
   end

   assign move_valid  = valid_q;
   assign move_dir    = dir_q;
   assign move_repeat = repeat_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_move_input_scheduler.sv
// Bench for move_input_scheduler: one instance with auto-repeat, one without,
// both driven by the same button/ready/reset stimulus and compared every cycle
// against a command-level reference model.
module tb_move_input_scheduler;

   localparam int DELAY = 8;
   localparam int RATE  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn;
   logic       move_ready;
   logic [1:0] vld_w, rep_w, ovr_w;
   logic [3:0] dir_w;

   always #5 clk = ~clk;

   move_input_scheduler #(
      .REPEAT_EN(1'b1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .CNT_W(8)
   ) dut_rep (
      .clk(clk), .rst_n(rst_n), .btn(btn), .move_ready(move_ready),
      .move_valid(vld_w[0]), .move_dir(dir_w[1:0]),
      .move_repeat(rep_w[0]), .overrun(ovr_w[0])
   );

   move_input_scheduler #(
      .REPEAT_EN(1'b0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .CNT_W(8)
   ) dut_norep (
      .clk(clk), .rst_n(rst_n), .btn(btn), .move_ready(move_ready),
      .move_valid(vld_w[1]), .move_dir(dir_w[3:2]),
      .move_repeat(rep_w[1]), .overrun(ovr_w[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int xfer_cnt [2];

   // Reference model: a pending command, or a held direction with an
   // absolute cycle number at which its next repeat falls due.
   bit       m_pend [2];
   bit       m_hold [2];
   int       m_due  [2];
   int       m_dir  [2];
   bit       m_rep  [2];
   bit       m_ovr  [2];
   bit [3:0] m_prev [2];

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input bit [3:0] b, input bit rdy, input bit rstn);
      bit [3:0] e;
      int win;
      bit en;
      en = (k == 0);
      if (!rstn) begin
         m_pend[k] = 0; m_hold[k] = 0; m_dir[k] = 0; m_rep[k] = 0;
         m_ovr[k] = 0;  m_prev[k] = '0; m_due[k] = 0;
         return;
      end
      e = b & ~m_prev[k];
      win = 0;
      for (int i = 3; i >= 0; i--) if (e[i]) win = i;
      m_ovr[k] = 0;
      if (m_pend[k]) begin
         if (e != 0) m_ovr[k] = 1;
         if (rdy) begin
            m_pend[k] = 0;
            if (en && b[m_dir[k]]) begin
               m_hold[k] = 1;
               m_due[k]  = cyc + (m_rep[k] ? RATE : DELAY);
            end
         end
      end else if (e != 0) begin
         m_pend[k] = 1; m_hold[k] = 0; m_dir[k] = win; m_rep[k] = 0;
         m_ovr[k]  = ($countones(e) > 1);
      end else if (m_hold[k]) begin
         if (!b[m_dir[k]]) begin
            m_hold[k] = 0;
         end else if (cyc == m_due[k]) begin
            m_pend[k] = 1; m_hold[k] = 0; m_rep[k] = 1;
         end
      end
      m_prev[k] = b;
   endtask

   task automatic step(input bit [3:0] b, input bit rdy, input bit rstn);
      btn = b; move_ready = rdy; rst_n = rstn;
      for (int k = 0; k < 2; k++) begin
         if (rstn && vld_w[k] && rdy) xfer_cnt[k]++;
         model_step(k, b, rdy, rstn);
      end
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("valid k%0d c%0d", k, cyc), int'(vld_w[k]), int'(m_pend[k]));
         check_eq($sformatf("overrun k%0d c%0d", k, cyc), int'(ovr_w[k]), int'(m_ovr[k]));
         if (m_pend[k]) begin
            check_eq($sformatf("dir k%0d c%0d", k, cyc), int'(dir_w[2*k +: 2]), m_dir[k]);
            check_eq($sformatf("repeat k%0d c%0d", k, cyc), int'(rep_w[k]), int'(m_rep[k]));
         end
      end
      cyc++;
   endtask

   task automatic repeat_step(input int n, input bit [3:0] b, input bit rdy);
      for (int i = 0; i < n; i++) step(b, rdy, 1'b1);
   endtask

   initial begin
      bit [3:0] rb;
      btn = '0; move_ready = 1'b1; rst_n = 1'b0;

      // Reset
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         check_eq("reset valid",   int'(vld_w[k]), 0);
         check_eq("reset dir",     int'(dir_w[2*k +: 2]), 0);
         check_eq("reset repeat",  int'(rep_w[k]), 0);
         check_eq("reset overrun", int'(ovr_w[k]), 0);
      end

      // Single press
      xfer_cnt[0] = 0; xfer_cnt[1] = 0;
      repeat_step(3, 4'b0001, 1'b1);
      repeat_step(15, 4'b0000, 1'b1);
      check_eq("single xfers rep",   xfer_cnt[0], 1);
      check_eq("single xfers norep", xfer_cnt[1], 1);

      // Simultaneous press: right wins, left dropped
      xfer_cnt[0] = 0; xfer_cnt[1] = 0;
      repeat_step(3, 4'b1010, 1'b1);
      repeat_step(5, 4'b0000, 1'b1);
      check_eq("simul xfers", xfer_cnt[0], 1);

      // Backpressure with a second press while waiting
      repeat_step(4, 4'b0100, 1'b0);
      repeat_step(6, 4'b1100, 1'b0);
      repeat_step(5, 4'b0000, 1'b1);

      // Auto-repeat hold
      xfer_cnt[0] = 0; xfer_cnt[1] = 0;
      repeat_step(40, 4'b0001, 1'b1);
      repeat_step(5, 4'b0000, 1'b1);
      check_eq("hold xfers rep",   xfer_cnt[0], 8);
      check_eq("hold xfers norep", xfer_cnt[1], 1);

      // Repeat cancelled by a new press
      repeat_step(20, 4'b0010, 1'b1);
      repeat_step(15, 4'b0110, 1'b1);
      repeat_step(5, 4'b0000, 1'b1);

      // Reset while a command is pending, button still held
      step(4'b0001, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      check_eq("midreset valid", int'(vld_w[0]), 0);
      repeat_step(4, 4'b0001, 1'b1);
      repeat_step(3, 4'b0000, 1'b1);

      // Randomised traffic
      rb = '0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 40) == 0) rb = 4'($urandom_range(0, 15));
         step(rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
